// File: rtl/multiplicador_sequencial.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a start/done handshake.
// One add-and-shift step per cycle through a 17-bit Adder; 18-cycle throughput.

module Adder (
  input  logic [15:0] OperandoA,
  input  logic [15:0] OperandoB,
  output logic [16:0] Soma
);

  assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule

module multiplicador_sequencial (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        St,
  input  logic [15:0] OperandoA,
  input  logic [15:0] OperandoB,
  output logic [31:0] Produto,
  output logic        Done,
  output logic        Idle
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] m;
  logic [31:0] p;
  logic [3:0]  cnt;
  logic [16:0] soma;
  logic [31:0] p_next;

  Adder u_adder (
    .OperandoA (p[31:16]),
    .OperandoB (m),
    .Soma      (soma)
  );

  // The adder carry becomes the new P[31]; otherwise a plain right shift.
  always_comb begin
    p_next = {1'b0, p[31:16], p[15:1]};
    if (p[0]) begin
      p_next = {soma, p[15:1]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      m       <= '0;
      p       <= '0;
      cnt     <= '0;
      Produto <= '0;
      Done    <= 1'b0;
      Idle    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (St) begin
            m     <= OperandoA;
            p     <= {16'h0000, OperandoB};
            cnt   <= '0;
            state <= CALC;
            Idle  <= 1'b0;
          end
        end
        CALC: begin
          p   <= p_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            Produto <= p_next;
            state   <= DONE;
            Done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
          Idle  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Done  <= 1'b0;
          Idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Scenario-driven bench for multiplicador_sequencial: expected products are queued
// when a start is driven and popped when the Done pulse shows up.

module tb_multiplicador_sequencial;

  logic        Clk;
  logic        Reset;
  logic        St;
  logic [15:0] OperandoA;
  logic [15:0] OperandoB;
  logic [31:0] Produto;
  logic        Done;
  logic        Idle;

  int checks;
  int failures;
  int done_count;
  logic [31:0] exp_q[$];

  multiplicador_sequencial dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .St        (St),
    .OperandoA (OperandoA),
    .OperandoB (OperandoB),
    .Produto   (Produto),
    .Done      (Done),
    .Idle      (Idle)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Done === 1'b1) done_count <= done_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
    exp_q.push_back(32'(a) * 32'(b));
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Ticks until Done is seen or the budget runs out; n = ticks taken.
  task automatic wait_done(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (Done === 1'b1) begin
        n  = i;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    St = 1'b0;
    OperandoA = '0;
    OperandoB = '0;
    Reset = 1'b0;
    #2 Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (Produto !== 32'd0) begin
      failures++;
      $display("FAIL reset_produto got=%h exp=%h", Produto, 32'd0);
    end
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", Done);
    end
    checks++;
    if (Idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=1", Idle);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    bit ok;
    logic [31:0] e;
    OperandoA = 16'd3;
    OperandoB = 16'd5;
    St = 1'b1;
    push_exp(16'd3, 16'd5);
    tick();
    St = 1'b0;
    checks++;
    if (Idle !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_idle got=%b exp=0", Idle);
    end
    wait_done(n, ok);
    checks++;
    if (!ok || n != 16) begin
      failures++;
      $display("FAIL basic_done_latency got=%0d exp=16", n);
    end
    e = pop_exp();
    checks++;
    if (Produto !== e) begin
      failures++;
      $display("FAIL basic_produto got=%h exp=%h", Produto, e);
    end
    checks++;
    if (Idle !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_during_done got=%b exp=0", Idle);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Idle !== 1'b1) begin
      failures++;
      $display("FAIL basic_return_idle got done=%b idle=%b exp done=0 idle=1", Done, Idle);
    end
    tick();
  endtask

  task automatic test_carry();
    int n;
    bit ok;
    logic [31:0] e;
    OperandoA = 16'hFFFF;
    OperandoB = 16'hFFFF;
    St = 1'b1;
    push_exp(16'hFFFF, 16'hFFFF);
    tick();
    St = 1'b0;
    wait_done(n, ok);
    e = pop_exp();
    checks++;
    if (!ok || Produto !== e || e !== 32'hFFFE0001) begin
      failures++;
      $display("FAIL carry_produto got=%h exp=%h ok=%0d", Produto, 32'hFFFE0001, ok);
    end
    tick();
    tick();
  endtask

  task automatic test_zero();
    int n;
    bit ok;
    logic [31:0] e;
    OperandoA = 16'h0000;
    OperandoB = 16'h1234;
    St = 1'b1;
    push_exp(16'h0000, 16'h1234);
    tick();
    St = 1'b0;
    repeat (5) tick();
    checks++;
    if (Produto !== 32'hFFFE0001) begin
      failures++;
      $display("FAIL zero_hold_previous got=%h exp=%h", Produto, 32'hFFFE0001);
    end
    wait_done(n, ok);
    e = pop_exp();
    checks++;
    if (!ok || Produto !== e) begin
      failures++;
      $display("FAIL zero_a_produto got=%h exp=%h ok=%0d", Produto, e, ok);
    end
    tick();
    tick();
    OperandoA = 16'h1234;
    OperandoB = 16'h0000;
    St = 1'b1;
    push_exp(16'h1234, 16'h0000);
    tick();
    St = 1'b0;
    wait_done(n, ok);
    e = pop_exp();
    checks++;
    if (!ok || Produto !== e) begin
      failures++;
      $display("FAIL zero_b_produto got=%h exp=%h ok=%0d", Produto, e, ok);
    end
    tick();
    tick();
  endtask

  task automatic test_busy_ignored();
    int n;
    bit ok;
    int dc0;
    logic [31:0] e;
    dc0 = done_count;
    OperandoA = 16'h00FF;
    OperandoB = 16'h0101;
    St = 1'b1;
    push_exp(16'h00FF, 16'h0101);
    tick();
    St = 1'b0;
    repeat (3) tick();
    OperandoA = 16'h1111;
    OperandoB = 16'h2222;
    St = 1'b1;
    tick();
    St = 1'b0;
    wait_done(n, ok);
    e = pop_exp();
    checks++;
    if (!ok || Produto !== e || e !== 32'h0000FFFF) begin
      failures++;
      $display("FAIL busy_produto got=%h exp=%h ok=%0d", Produto, 32'h0000FFFF, ok);
    end
    repeat (25) tick();
    checks++;
    if (done_count - dc0 != 1) begin
      failures++;
      $display("FAIL busy_done_pulses got=%0d exp=1", done_count - dc0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    logic [31:0] e;
    OperandoA = 16'd100;
    OperandoB = 16'd200;
    for (int i = 0; i < 3; i++) push_exp(16'd100, 16'd200);
    St = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done(n, ok);
      if (i == 2) St = 1'b0;
      if (i > 0) begin
        checks++;
        if (!ok || n != 18) begin
          failures++;
          $display("FAIL b2b_period_%0d got=%0d exp=18", i, n);
        end
      end
      e = pop_exp();
      checks++;
      if (!ok || Produto !== e) begin
        failures++;
        $display("FAIL b2b_produto_%0d got=%h exp=%h", i, Produto, e);
      end
    end
    repeat (3) tick();
    checks++;
    if (Idle !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stop_idle got=%b exp=1", Idle);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    int dc0;
    logic [31:0] e;
    OperandoA = 16'h1234;
    OperandoB = 16'h5678;
    St = 1'b1;
    tick();
    St = 1'b0;
    repeat (7) tick();
    dc0 = done_count;
    #3 Reset = 1'b1;
    #1;
    checks++;
    if (Produto !== 32'd0 || Idle !== 1'b1 || Done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got produto=%h idle=%b done=%b exp produto=0 idle=1 done=0",
               Produto, Idle, Done);
    end
    tick();
    Reset = 1'b0;
    repeat (25) tick();
    checks++;
    if (done_count != dc0) begin
      failures++;
      $display("FAIL midreset_no_done got=%0d exp=%0d", done_count, dc0);
    end
    OperandoA = 16'd7;
    OperandoB = 16'd9;
    St = 1'b1;
    push_exp(16'd7, 16'd9);
    tick();
    St = 1'b0;
    wait_done(n, ok);
    e = pop_exp();
    checks++;
    if (!ok || Produto !== e || e !== 32'd63) begin
      failures++;
      $display("FAIL midreset_fresh_produto got=%h exp=%h ok=%0d", Produto, 32'd63, ok);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done_count = 0;
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
